// File: rtl/vita_packet_mux36_if.sv
// Port bundle for the VITA packet mux: NUMCHAN 36-bit input streams and one merged output stream.
interface vita_packet_mux36_if #(
  parameter int NUMCHAN = 1
);
  // Handshake: a word moves on a port in exactly the cycles where its src_rdy and dst_rdy are
  // both high; src_rdy may not depend on dst_rdy, dst_rdy may depend on src_rdy.
  logic [36*NUMCHAN-1:0] in_data;
  logic [NUMCHAN-1:0]    in_src_rdy;
  logic [NUMCHAN-1:0]    in_dst_rdy;
  logic [35:0]           out_data;
  logic                  out_src_rdy;
  logic                  out_dst_rdy;

  modport slave (
    input  in_data, in_src_rdy, out_dst_rdy,
    output in_dst_rdy, out_data, out_src_rdy
  );

  modport master (
    output in_data, in_src_rdy, out_dst_rdy,
    input  in_dst_rdy, out_data, out_src_rdy
  );
endinterface

// File: rtl/vita_packet_mux36.sv
// Round-robin per-packet merge of NUMCHAN VITA streams; each output packet gets SID_BASE + channel
// inserted after its header, with the has-SID bit set and the length adjusted to match.
module vita_packet_mux36 #(
  parameter int          NUMCHAN  = 1,
  parameter logic [31:0] SID_BASE = 32'h0
) (
  input  logic                clk,
  input  logic                rst,
  vita_packet_mux36_if.slave  bus,
  output logic [2:0]          state_dbg
);
  localparam int CW = (NUMCHAN > 1) ? $clog2(NUMCHAN) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GET_HDR   = 3'd1,
    SKIP_SID  = 3'd2,
    WRITE_HDR = 3'd3,
    WRITE_SID = 3'd4,
    FORWARD   = 3'd5
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] c, last, pick;
  logic          found;
  logic [31:0]   hdr;
  logic          hdr_eof, had_sid;
  logic [33:0]   sel_data;
  logic          sel_vld;
  logic          grant_rdy;
  logic [31:0]   hdr_out;
  logic          unused_bits;

  assign state_dbg = state;

  // Only the granted channel is visible to the rest of the datapath.
  always_comb begin
    sel_data    = '0;
    sel_vld     = 1'b0;
    unused_bits = 1'b0;
    for (int i = 0; i < NUMCHAN; i++) begin
      unused_bits = unused_bits ^ (^bus.in_data[36*i+34 +: 2]);
      if (c == CW'(i)) begin
        sel_data = bus.in_data[36*i +: 34];
        sel_vld  = bus.in_src_rdy[i];
      end
    end
  end

  // First requester after the previous grant, wrapping modulo NUMCHAN.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 1; i <= NUMCHAN; i++) begin
      for (int j = 0; j < NUMCHAN; j++) begin
        if (!found && (j == (int'(last) + i) % NUMCHAN) && bus.in_src_rdy[j]) begin
          found = 1'b1;
          pick  = CW'(j);
        end
      end
    end
  end

  assign hdr_out = {hdr[31:29], 1'b1, hdr[27:16], had_sid ? hdr[15:0] : hdr[15:0] + 16'd1};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    grant_rdy       = 1'b0;
    bus.out_data    = '0;
    bus.out_src_rdy = 1'b0;
    bus.in_dst_rdy  = '0;
    case (state)
      IDLE: begin
        if (found) state_nxt = GET_HDR;
      end
      GET_HDR: begin
        grant_rdy = 1'b1;
        if (sel_vld && sel_data[32])
          state_nxt = (sel_data[28] && !sel_data[33]) ? SKIP_SID : WRITE_HDR;
      end
      SKIP_SID: begin
        grant_rdy = 1'b1;
        if (sel_vld) state_nxt = WRITE_HDR;
      end
      WRITE_HDR: begin
        bus.out_data    = {2'b00, 1'b0, 1'b1, hdr_out};
        bus.out_src_rdy = 1'b1;
        if (bus.out_dst_rdy) state_nxt = WRITE_SID;
      end
      WRITE_SID: begin
        bus.out_data    = {2'b00, hdr_eof, 1'b0, SID_BASE + 32'(c)};
        bus.out_src_rdy = 1'b1;
        if (bus.out_dst_rdy) state_nxt = hdr_eof ? IDLE : FORWARD;
      end
      FORWARD: begin
        bus.out_data    = {2'b00, sel_data};
        bus.out_src_rdy = sel_vld;
        grant_rdy       = bus.out_dst_rdy;
        if (sel_vld && bus.out_dst_rdy && sel_data[33]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    for (int i = 0; i < NUMCHAN; i++) begin
      if (c == CW'(i)) bus.in_dst_rdy[i] = grant_rdy;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c       <= '0;
      last    <= CW'(NUMCHAN - 1);
      hdr     <= '0;
      hdr_eof <= 1'b0;
      had_sid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            c    <= pick;
            last <= pick;
          end
        end
        GET_HDR: begin
          if (sel_vld && sel_data[32]) begin
            hdr     <= sel_data[31:0];
            hdr_eof <= sel_data[33];
            had_sid <= sel_data[28];
          end
        end
        SKIP_SID: begin
          if (sel_vld) hdr_eof <= sel_data[33];
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_vita_packet_mux36.sv
// Randomized bench for vita_packet_mux36: packets are modelled per channel and matched against the
// merged stream by the SID word each output packet carries.
module tb_vita_packet_mux36;
  localparam int          NUMCHAN  = 2;
  localparam logic [31:0] SID_BASE = 32'h100;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] state_dbg;

  vita_packet_mux36_if #(.NUMCHAN(NUMCHAN)) bus ();

  vita_packet_mux36 #(.NUMCHAN(NUMCHAN), .SID_BASE(SID_BASE)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [35:0] src_q[NUMCHAN][$];
  logic [35:0] exp_q[NUMCHAN][$];
  logic [35:0] cur_pkt[$];
  logic [31:0] sid_log[$];
  int          cyc = 0;
  int          lat_start = 0;
  bit          lat_arm = 0;
  int          lat_seen = -1;
  int          p_src = 100;
  int          p_dst = 100;
  bit          t1_watch = 0;

  task automatic check_eq(input string tag, input logic [35:0] got, input logic [35:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: input words of one packet and the output packet the merge should produce.
  task automatic send_pkt(input int ch, input logic [31:0] hdr, input bit sid_word,
                          input logic [31:0] sid_val, input int npay);
    logic [35:0] w[$];
    int          total;
    bit          has, skip, sid_eof;
    logic [15:0] len;
    total = 1 + (sid_word ? 1 : 0) + npay;
    w.push_back({2'($urandom), (total == 1), 1'b1, hdr});
    if (sid_word) w.push_back({2'($urandom), (total == 2), 1'b0, sid_val});
    for (int k = 0; k < npay; k++)
      w.push_back({2'($urandom), (w.size() == total - 1), 1'b0, 32'($urandom)});
    foreach (w[k]) src_q[ch].push_back(w[k]);

    has     = hdr[28];
    skip    = has && (total > 1);
    sid_eof = (total == (skip ? 2 : 1));
    len     = has ? hdr[15:0] : 16'(hdr[15:0] + 1);
    exp_q[ch].push_back({4'b0001, hdr[31:29], 1'b1, hdr[27:16], len});
    exp_q[ch].push_back({2'b00, sid_eof, 1'b0, SID_BASE + 32'(ch)});
    for (int k = (skip ? 2 : 1); k < total; k++) exp_q[ch].push_back({2'b00, w[k][33:0]});
  endtask

  task automatic send_junk(input int ch, input logic [31:0] val);
    src_q[ch].push_back({4'b0000, val});
  endtask

  task automatic finish_pkt();
    logic [35:0] w1;
    logic [31:0] d;
    int          ch;
    if (cur_pkt.size() < 2) begin
      check_eq("pkt_short", 36'(cur_pkt.size()), 36'd2);
      cur_pkt.delete();
      return;
    end
    w1 = cur_pkt[1];
    d  = w1[31:0] - SID_BASE;
    if (d >= NUMCHAN) begin
      check_eq("sid_range", w1, {4'b0000, SID_BASE});
      cur_pkt.delete();
      return;
    end
    ch = int'(d);
    sid_log.push_back(w1[31:0]);
    foreach (cur_pkt[k]) begin
      if (exp_q[ch].size() == 0) check_eq("exp_avail", 36'(exp_q[ch].size()), 36'd1);
      else check_eq($sformatf("ch%0d_word", ch), cur_pkt[k], exp_q[ch].pop_front());
    end
    cur_pkt.delete();
  endtask

  // One cycle: sample handshakes at the falling edge, drive new inputs just after the rising edge.
  task automatic step();
    bit acc[NUMCHAN];
    @(negedge clk);
    check_eq("dst_onehot", 36'($countones(bus.in_dst_rdy) <= 1), 36'd1);
    if (t1_watch) check_eq("t1_ch0_dst", 36'(bus.in_dst_rdy[0]), 36'd0);
    for (int ch = 0; ch < NUMCHAN; ch++) begin
      acc[ch] = 1'b0;
      if (bus.in_src_rdy[ch] && bus.in_dst_rdy[ch]) begin
        void'(src_q[ch].pop_front());
        acc[ch] = 1'b1;
      end
    end
    if (bus.out_src_rdy && bus.out_dst_rdy) begin
      if (lat_arm) begin
        lat_seen = cyc - lat_start;
        lat_arm  = 0;
      end
      cur_pkt.push_back(bus.out_data);
      if (bus.out_data[33]) finish_pkt();
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int ch = 0; ch < NUMCHAN; ch++) begin
      if (bus.in_src_rdy[ch] && !acc[ch]) begin
        // hold the offered word until it is taken
      end else if (src_q[ch].size() > 0 && $urandom_range(99) < p_src) begin
        bus.in_src_rdy[ch]        = 1'b1;
        bus.in_data[36*ch +: 36] = src_q[ch][0];
      end else begin
        bus.in_src_rdy[ch]        = 1'b0;
        bus.in_data[36*ch +: 36] = {4'($urandom), 32'($urandom)};
      end
    end
    bus.out_dst_rdy = ($urandom_range(99) < p_dst);
  endtask

  function automatic bit all_empty();
    bit e = (cur_pkt.size() == 0);
    for (int ch = 0; ch < NUMCHAN; ch++)
      if (src_q[ch].size() != 0 || exp_q[ch].size() != 0) e = 0;
    return e;
  endfunction

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (!all_empty() && n < budget) begin
      step();
      n++;
    end
    check_eq({tag, "_drained"}, 36'(all_empty()), 36'd1);
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    bus.in_src_rdy  = '0;
    bus.out_dst_rdy = 1'b1;
    for (int ch = 0; ch < NUMCHAN; ch++) begin
      src_q[ch].delete();
      exp_q[ch].delete();
    end
    @(posedge clk); cyc++;
    @(posedge clk); cyc++;
    #1;
    rst = 1'b0;
    cur_pkt.delete();
    @(negedge clk);
    check_eq("rst_out_src_rdy", 36'(bus.out_src_rdy), 36'd0);
    check_eq("rst_in_dst_rdy", 36'(bus.in_dst_rdy), 36'd0);
    check_eq("rst_out_data", bus.out_data, 36'd0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1);
  end

  initial begin
    bus.in_data     = '0;
    bus.in_src_rdy  = '0;
    bus.out_dst_rdy = 1'b0;
    do_reset();

    // Single packet on channel 1 and header latency.
    p_src = 100; p_dst = 100;
    lat_start = cyc + 1;
    lat_arm   = 1;
    t1_watch  = 1;
    send_pkt(1, 32'h0000_0003, 0, 32'h0, 2);
    drain("t1", 50);
    t1_watch = 0;
    check_eq("t1_latency", 36'(lat_seen), 36'd2);

    // Both channels busy: strict alternation starting at channel 0.
    sid_log.delete();
    for (int k = 0; k < 4; k++)
      for (int ch = 0; ch < NUMCHAN; ch++)
        send_pkt(ch, $urandom & 32'hEFFF_FFFF, 0, 32'h0, $urandom_range(1, 3));
    drain("t2", 200);
    check_eq("t2_count", 36'(sid_log.size()), 36'd8);
    foreach (sid_log[k]) check_eq($sformatf("t2_sid%0d", k), 36'(sid_log[k]), 36'(SID_BASE + 32'(k % 2)));

    // Existing SID replaced; one-line packet with length wrap.
    send_pkt(0, 32'h1000_0005, 1, 32'hDEAD_BEEF, 3);
    drain("t3", 50);
    send_pkt(0, 32'h0000_FFFF, 0, 32'h0, 0);
    drain("t4", 50);

    // Throttled random traffic.
    p_src = 60; p_dst = 60;
    for (int n = 0; n < 1000; n++) begin
      logic [31:0] hdr;
      int          npay;
      bit          sw;
      hdr = $urandom;
      if ($urandom_range(9) < 2) hdr[15:0] = 16'hFFFF;
      npay = $urandom_range(0, 4);
      sw   = hdr[28] && (npay > 0 || $urandom_range(1) == 1);
      send_pkt($urandom_range(0, NUMCHAN - 1), hdr, sw, $urandom, npay);
    end
    drain("t5", 60000);

    // Reset in the middle of a forwarded packet, then junk before the next header.
    p_src = 100; p_dst = 100;
    send_pkt(0, 32'h0000_0010, 0, 32'h0, 12);
    begin
      int n = 0;
      while (cur_pkt.size() < 4 && n < 40) begin
        step();
        n++;
      end
      check_eq("t6_midpkt", 36'(cur_pkt.size() >= 4), 36'd1);
    end
    do_reset();
    send_junk(0, 32'h1234_5678);
    send_pkt(0, 32'h0000_0002, 0, 32'h0, 2);
    drain("t6", 50);
    repeat (4) step();
    check_eq("end_idle_out", 36'(bus.out_src_rdy), 36'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vita_packet_mux36.md
# vita_packet_mux36

Merges NUMCHAN 36-bit VITA packet streams into one output stream, inserting a stream ID (SID) word after each packet header. Per-packet round-robin arbitration; header's has-SID bit (28) set and length field (15:0) incremented by one line. Sits on the host-bound path as the transmit-side counterpart of the SID-stripping demux, so SID_BASE + channel index on the wire round-trips to the same channel.

## Interface
- NUMCHAN, 1: number of input channels (1..16).
- SID_BASE, 0: 32-bit SID value for channel 0; channel c gets SID_BASE + c.

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_data  in  36*NUMCHAN  channel c at bits [36c+35:36c]; bit 32 SOF, bit 33 EOF, bits 35:34 ignored.
- in_src_rdy  in  NUMCHAN  per-channel word valid.
- in_dst_rdy  out  NUMCHAN  per-channel word accepted.
- out_data  out  36  merged stream, same format; bits 35:34 always 0.
- out_src_rdy  out  1  output word valid.
- out_dst_rdy  in  1  downstream ready.

## Operation
- Transfer on any port only when src_rdy && dst_rdy in the same cycle.
- Registers: state, grant index c, round-robin pointer last, hdr[31:0], hdr_eof, had_sid.
- States:
  - IDLE: all in_dst_rdy 0, out_src_rdy 0. If any in_src_rdy set: c <= first channel with in_src_rdy, searching last+1, last+2, ... mod NUMCHAN; last <= c; -> GET_HDR. Otherwise stay.
  - GET_HDR: in_dst_rdy[c]=1. On transfer with SOF: hdr <= word[31:0], hdr_eof <= EOF, had_sid <= bit 28; -> SKIP_SID if bit 28 and not EOF, else WRITE_HDR. On transfer without SOF: word discarded, stay (drains mid-packet garbage).
  - SKIP_SID: in_dst_rdy[c]=1. On transfer: existing SID word discarded; hdr_eof <= EOF; -> WRITE_HDR.
  - WRITE_HDR: out_data = {2'b00, 1'b0, 1'b1, hdr'}; out_src_rdy=1. hdr' = hdr with bit 28 set; if !had_sid, hdr'[15:0] = hdr[15:0] + 1 mod 2^16, else unchanged. On accept -> WRITE_SID.
  - WRITE_SID: out_data = {2'b00, hdr_eof, 1'b0, SID_BASE + c (mod 2^32)}; out_src_rdy=1. On accept -> IDLE if hdr_eof else FORWARD.
  - FORWARD: out_data = in_data[c], out_src_rdy = in_src_rdy[c], in_dst_rdy[c] = out_dst_rdy. Input SOF bit passed unchanged. Transfer with EOF -> IDLE.
- Non-granted channels: in_dst_rdy 0 at all times.
- Bits 31:29 and 27:16 of header pass unchanged.

## Timing
- Reset: state IDLE, last = NUMCHAN-1 (channel 0 first priority), c=0, out_src_rdy 0, in_dst_rdy all 0, out_data 0 outside WRITE_HDR/WRITE_SID/FORWARD.
- rst mid-packet: abort immediately to IDLE; partial output packet not completed; next accepted input word must carry SOF (non-SOF words drained in GET_HDR).
- Latency: grant cycle (IDLE) + header capture (GET_HDR) -> header on out_data 2 cycles after first in_src_rdy seen with out_dst_rdy high; SKIP_SID adds 1.
- Per-packet overhead: 3 idle-input cycles (IDLE, WRITE_HDR, WRITE_SID) excluding skipped SID; FORWARD is full rate, combinational ready/valid pass-through.
- Arbitration changes only in IDLE; a packet is never interleaved with another.
- Length wrap: 0xFFFF -> 0x0000, no saturation.
- Header with SOF+EOF (one-line packet): output two lines, header then SID word carrying EOF.

## Test plan
- NUMCHAN=2, SID_BASE=0x100; ch1 sends hdr 0x0000_0003 (SOF), 2 payload words (last EOF) -> out: 0x1_1000_0004, 0x0_0000_0101, payload, EOF on last; in_dst_rdy[0] held 0.
- Both channels continuously ready, 4 packets each -> output order ch0,ch1,ch0,ch1...; no interleave; SIDs alternate 0x100/0x101.
- Header 0x1000_0005 with SID word 0xDEAD_BEEF on ch0 -> SID replaced by 0x100, length stays 5, 0xDEAD_BEEF absent from output.
- One-line packet hdr 0x0000_FFFF with SOF+EOF -> out 0x1_1000_0000 then 0x2_0000_0100 (EOF set), state back to IDLE.
- Random out_dst_rdy / in_src_rdy throttling over 1000 packets -> scoreboard matches exactly, no dropped or duplicated words.
- Assert rst during FORWARD, then ch0 sends non-SOF word followed by valid packet -> junk word discarded, valid packet emitted with SID inserted.
